// File: rtl/uart_boot_loader_if.sv
// Bus between the UART word receiver, the boot loader and instruction memory.
// The master side feeds words and restart requests; the slave side is the
// loader, which drives memory writes and the core-reset/status flags.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic [31:0]           word_in;
  logic                  word_valid;
  logic                  boot_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_reset;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output word_in, word_valid, boot_req,
    input  mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_error
  );

  modport slave (
    input  word_in, word_valid, boot_req,
    output mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_error
  );

endinterface

// File: rtl/uart_boot_loader.sv
// Boot loader: parses magic / length / payload / checksum frames arriving as
// 32-bit words, writes the payload into instruction memory and releases the
// core from reset only after a frame with a matching checksum.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          BASE_ADDR  = 0,
  parameter int          MAX_WORDS  = 1024,
  parameter logic [31:0] MAGIC      = 32'hB007_10AD
) (
  input logic              clk,
  input logic              reset,
  uart_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    WAIT_LEN,
    LOAD,
    WAIT_CSUM,
    RUN,
    ERROR
  } state_t;

  localparam logic [31:0] BASE_WORD = 32'(BASE_ADDR);
  localparam logic [31:0] MAX_LEN   = 32'(MAX_WORDS);

  state_t                state_q, state_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           index_q, index_d;
  logic [31:0]           sum_q, sum_d;
  logic                  memWe_q, memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [31:0]           memWdata_q, memWdata_d;
  logic                  cpuReset_q;
  logic                  loadDone_q;
  logic                  loadError_q;
  logic [31:0]           indexNext;
  logic [31:0]           sumNext;

  // Next-state and write decode; a restart request wins over a word arriving
  // in the same cycle, and that word is dropped entirely.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    index_d    = index_q;
    sum_d      = sum_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    indexNext  = index_q + 32'd1;
    sumNext    = sum_q + bus.word_in;

    if (bus.boot_req) begin
      state_d = WAIT_MAGIC;
      index_d = 32'd0;
      sum_d   = 32'd0;
    end else if (bus.word_valid) begin
      case (state_q)
        WAIT_MAGIC: begin
          if (bus.word_in == MAGIC) state_d = WAIT_LEN;
        end
        WAIT_LEN: begin
          len_d   = bus.word_in;
          index_d = 32'd0;
          sum_d   = 32'd0;
          if (bus.word_in > MAX_LEN)      state_d = ERROR;
          else if (bus.word_in == 32'd0)  state_d = WAIT_CSUM;
          else                            state_d = LOAD;
        end
        LOAD: begin
          memWe_d    = 1'b1;
          memAddr_d  = ADDR_WIDTH'(BASE_WORD + index_q);
          memWdata_d = bus.word_in;
          sum_d      = sumNext;
          index_d    = indexNext;
          if (indexNext == len_q) state_d = WAIT_CSUM;
        end
        WAIT_CSUM: begin
          if (bus.word_in == sum_q) state_d = RUN;
          else                      state_d = ERROR;
        end
        default: begin
        end
      endcase
    end
  end

  // State, datapath and registered outputs; status flags follow the next state
  // so they change in the same cycle as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_MAGIC;
      len_q       <= 32'd0;
      index_q     <= 32'd0;
      sum_q       <= 32'd0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= 32'd0;
      cpuReset_q  <= 1'b1;
      loadDone_q  <= 1'b0;
      loadError_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      index_q     <= index_d;
      sum_q       <= sum_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      cpuReset_q  <= (state_d != RUN);
      loadDone_q  <= (state_d == RUN);
      loadError_q <= (state_d == ERROR);
    end
  end

  assign bus.mem_we     = memWe_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.cpu_reset  = cpuReset_q;
  assign bus.load_done  = loadDone_q;
  assign bus.load_error = loadError_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: two instances (base address 0 and 1022),
// expected memory writes queued by the stimulus and popped by write monitors.
module tb_uart_boot_loader;

  localparam logic [31:0] MAGIC = 32'hB007_10AD;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  wr_t  qA[$];
  wr_t  qB[$];

  uart_boot_loader_if #(.ADDR_WIDTH(10)) ifA ();
  uart_boot_loader_if #(.ADDR_WIDTH(10)) ifB ();

  uart_boot_loader #(
    .ADDR_WIDTH(10), .BASE_ADDR(0), .MAX_WORDS(1024), .MAGIC(MAGIC)
  ) dutA (
    .clk(clk), .reset(reset), .bus(ifA)
  );

  uart_boot_loader #(
    .ADDR_WIDTH(10), .BASE_ADDR(1022), .MAX_WORDS(1024), .MAGIC(MAGIC)
  ) dutB (
    .clk(clk), .reset(reset), .bus(ifB)
  );

  // Free-running clock and cycle counter used to time-stamp expected writes.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor for instance A: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    wr_t e;
    if (ifA.mem_we !== 1'b0) begin
      checks++;
      if (qA.size() == 0) begin
        failures++;
        $display("[TB] FAIL writeA unexpected: got addr=%0d data=%h cyc=%0d, required no write",
                 ifA.mem_addr, ifA.mem_wdata, cyc);
      end else begin
        e = qA.pop_front();
        if (ifA.mem_addr !== e.addr || ifA.mem_wdata !== e.data || cyc != e.cyc) begin
          failures++;
          $display("[TB] FAIL writeA: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   ifA.mem_addr, ifA.mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Write monitor for instance B.
  always @(negedge clk) begin
    wr_t e;
    if (ifB.mem_we !== 1'b0) begin
      checks++;
      if (qB.size() == 0) begin
        failures++;
        $display("[TB] FAIL writeB unexpected: got addr=%0d data=%h cyc=%0d, required no write",
                 ifB.mem_addr, ifB.mem_wdata, cyc);
      end else begin
        e = qB.pop_front();
        if (ifB.mem_addr !== e.addr || ifB.mem_wdata !== e.data || cyc != e.cyc) begin
          failures++;
          $display("[TB] FAIL writeB: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                   ifB.mem_addr, ifB.mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Drive one cycle of input to an instance; queue the write it should cause.
  task automatic applyStimulus(input int which, input logic valid, input logic [31:0] w,
                               input logic boot, input logic expWrite, input logic [9:0] expAddr);
    wr_t e;
    e.addr = expAddr;
    e.data = w;
    e.cyc  = cyc + 1;
    if (which == 0) begin
      if (expWrite) qA.push_back(e);
      ifA.word_in = w; ifA.word_valid = valid; ifA.boot_req = boot;
    end else begin
      if (expWrite) qB.push_back(e);
      ifB.word_in = w; ifB.word_valid = valid; ifB.boot_req = boot;
    end
    @(posedge clk);
    #1;
    ifA.word_valid = 1'b0; ifA.boot_req = 1'b0;
    ifB.word_valid = 1'b0; ifB.boot_req = 1'b0;
  endtask

  task automatic sendWord(input int which, input logic [31:0] w);
    applyStimulus(which, 1'b1, w, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic sendPayload(input int which, input logic [31:0] w, input logic [9:0] addr);
    applyStimulus(which, 1'b1, w, 1'b0, 1'b1, addr);
  endtask

  task automatic bootPulse(input int which);
    applyStimulus(which, 1'b0, 32'd0, 1'b1, 1'b0, 10'd0);
  endtask

  // Compare the status flags of an instance against expected values.
  task automatic checkOutput(input int which, input string name, input logic expCpuReset,
                             input logic expDone, input logic expErr);
    logic [2:0] got;
    if (which == 0) got = {ifA.cpu_reset, ifA.load_done, ifA.load_error};
    else            got = {ifB.cpu_reset, ifB.load_done, ifB.load_error};
    checks++;
    if (got !== {expCpuReset, expDone, expErr}) begin
      failures++;
      $display("[TB] FAIL %s: got cpu_reset/done/error=%b, required %b",
               name, got, {expCpuReset, expDone, expErr});
    end
  endtask

  // Compare the memory-port outputs of instance A against expected values.
  task automatic checkMem(input string name, input logic expWe, input logic [9:0] expAddr,
                          input logic [31:0] expData);
    checks++;
    if (ifA.mem_we !== expWe || ifA.mem_addr !== expAddr || ifA.mem_wdata !== expData) begin
      failures++;
      $display("[TB] FAIL %s: got we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
               name, ifA.mem_we, ifA.mem_addr, ifA.mem_wdata, expWe, expAddr, expData);
    end
  endtask

  // Directed scenarios.
  initial begin
    reset = 1'b1;
    ifA.word_in = 32'd0; ifA.word_valid = 1'b0; ifA.boot_req = 1'b0;
    ifB.word_in = 32'd0; ifB.word_valid = 1'b0; ifB.boot_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput(0, "resetFlags", 1'b1, 1'b0, 1'b0);
    checkMem("resetMem", 1'b0, 10'd0, 32'd0);

    // Nominal three-word frame.
    sendWord(0, MAGIC);
    sendWord(0, 32'd3);
    sendPayload(0, 32'h1111_1111, 10'd0);
    sendPayload(0, 32'h2222_2222, 10'd1);
    sendPayload(0, 32'h3333_3333, 10'd2);
    checkOutput(0, "nominalBeforeCsum", 1'b1, 1'b0, 1'b0);
    sendWord(0, 32'h6666_6666);
    checkOutput(0, "nominalRun", 1'b0, 1'b1, 1'b0);

    // Words in RUN are ignored.
    sendWord(0, 32'hDEAD_BEEF);
    checkOutput(0, "runIgnoresWord", 1'b0, 1'b1, 1'b0);
    bootPulse(0);
    checkOutput(0, "bootFromRun", 1'b1, 1'b0, 1'b0);

    // Checksum wraps at 32 bits.
    sendWord(0, MAGIC);
    sendWord(0, 32'd2);
    sendPayload(0, 32'hFFFF_FFFF, 10'd0);
    sendPayload(0, 32'h0000_0002, 10'd1);
    sendWord(0, 32'h0000_0001);
    checkOutput(0, "wrapRun", 1'b0, 1'b1, 1'b0);
    bootPulse(0);

    sendWord(0, MAGIC);
    sendWord(0, 32'd2);
    sendPayload(0, 32'hFFFF_FFFF, 10'd0);
    sendPayload(0, 32'h0000_0002, 10'd1);
    sendWord(0, 32'h0000_0002);
    checkOutput(0, "wrapBadCsum", 1'b1, 1'b0, 1'b1);
    sendWord(0, MAGIC);
    checkOutput(0, "errorIgnoresWord", 1'b1, 1'b0, 1'b1);
    bootPulse(0);
    checkOutput(0, "bootFromError", 1'b1, 1'b0, 1'b0);

    // Resync past a garbage word, then an empty frame.
    sendWord(0, 32'h1234_5678);
    sendWord(0, MAGIC);
    sendWord(0, 32'd0);
    sendWord(0, 32'd0);
    checkOutput(0, "emptyFrameRun", 1'b0, 1'b1, 1'b0);
    bootPulse(0);

    // Length limit: MAX_WORDS accepted, MAX_WORDS+1 rejected.
    sendWord(0, MAGIC);
    sendWord(0, 32'd1024);
    checkOutput(0, "lenAtLimit", 1'b1, 1'b0, 1'b0);
    bootPulse(0);
    sendWord(0, MAGIC);
    sendWord(0, 32'd1025);
    checkOutput(0, "lenOverLimit", 1'b1, 1'b0, 1'b1);
    bootPulse(0);

    // Abort together with the second payload word; that word is not written.
    sendWord(0, MAGIC);
    sendWord(0, 32'd3);
    sendPayload(0, 32'hAAAA_0001, 10'd0);
    applyStimulus(0, 1'b1, 32'hAAAA_0002, 1'b1, 1'b0, 10'd0);
    checkOutput(0, "abortFlags", 1'b1, 1'b0, 1'b0);
    sendWord(0, 32'd5);
    sendWord(0, MAGIC);
    sendWord(0, 32'd2);
    sendPayload(0, 32'h0000_0005, 10'd0);
    sendPayload(0, 32'h0000_0007, 10'd1);
    sendWord(0, 32'h0000_000C);
    checkOutput(0, "afterAbortRun", 1'b0, 1'b1, 1'b0);
    bootPulse(0);

    // Back-to-back pulses with address wrap on instance B.
    sendWord(1, MAGIC);
    sendWord(1, 32'd4);
    sendPayload(1, 32'd1, 10'd1022);
    sendPayload(1, 32'd2, 10'd1023);
    sendPayload(1, 32'd3, 10'd0);
    sendPayload(1, 32'd4, 10'd1);
    sendWord(1, 32'd10);
    checkOutput(1, "backToBackRun", 1'b0, 1'b1, 1'b0);

    // Reset in the middle of LOAD, coinciding with a payload word.
    sendWord(0, MAGIC);
    sendWord(0, 32'd3);
    sendPayload(0, 32'h0000_ABCD, 10'd0);
    sendPayload(0, 32'h0000_1234, 10'd1);
    reset = 1'b1;
    sendWord(0, 32'h0000_5555);
    checkMem("midLoadResetMem", 1'b0, 10'd0, 32'd0);
    checkOutput(0, "midLoadResetFlags", 1'b1, 1'b0, 1'b0);
    checkOutput(1, "resetFromRunB", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      failures++;
      $display("[TB] FAIL pendingWrites: got %0d/%0d writes still expected, required 0/0",
               qA.size(), qB.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
